pci_tgt_bridge: RTL

PCI_TGT_BRIDGE -- requirements
Module: pci_tgt_bridge

---
 rtl/pci_tgt_bridge.sv | 94 +++++++++
 1 files changed

// File: rtl/pci_tgt_bridge.sv
// pci_tgt_bridge: single-data-phase PCI target to local-bus bridge with ack timeout.
module pci_tgt_bridge #(
    parameter int BAR_NUM = 0,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic              addr_vld,
    input  logic [7:0]        base_hit,
    input  logic              s_wrdn,
    input  logic              s_data,
    input  logic              s_data_vld,
    input  logic [3:0]        s_cbe,
    input  logic [31:0]       adio_out,
    output logic [31:0]       adio_in,
    output logic              s_ready,
    output logic              s_term,
    output logic              s_abort,
    output logic [ADDR_W-3:0] lb_addr,
    output logic              lb_wr,
    output logic              lb_rd,
    output logic [31:0]       lb_wdata,
    output logic [3:0]        lb_be,
    input  logic [31:0]       lb_rdata,
    input  logic              lb_ack
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_WAIT  = 3'd1;
    localparam logic [2:0] WR_ISSUE = 3'd2;
    localparam logic [2:0] RD_ISSUE = 3'd3;
    localparam logic [2:0] RD_WAIT  = 3'd4;
    localparam logic [2:0] RD_DONE  = 3'd5;
    localparam logic [7:0] TO       = 8'(TIMEOUT);

    logic [2:0] st, nxt;
    logic [7:0] cnt;
    logic       s_data_d, claim, fall, wait_st, expired, hit_tmo;
    logic [3:0] be_nxt;

    // The abort cycle is the one where cnt sits at TO; an ack in it is ignored.
    always_comb begin
        claim   = st == IDLE && addr_vld && base_hit[BAR_NUM];
        fall    = s_data_d && !s_data;
        wait_st = (st == WR_ISSUE && lb_be != 4'd0) || st == RD_WAIT;
        expired = wait_st && cnt == TO;
        hit_tmo = wait_st && !expired && !lb_ack && cnt == TO - 8'd1;
        be_nxt  = (st == WR_WAIT && s_data_vld) ? ~s_cbe : lb_be;
        nxt     = st;
        case (st)
            IDLE:     nxt = claim ? (s_wrdn ? WR_WAIT : RD_ISSUE) : IDLE;
            WR_WAIT:  nxt = s_data_vld ? WR_ISSUE : fall ? IDLE : WR_WAIT;
            WR_ISSUE: nxt = (lb_be == 4'd0 || lb_ack || expired) ? IDLE : WR_ISSUE;
            RD_ISSUE: nxt = RD_WAIT;
            RD_WAIT:  nxt = expired ? IDLE : lb_ack ? RD_DONE : RD_WAIT;
            RD_DONE:  nxt = (s_data_vld || fall) ? IDLE : RD_DONE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            s_data_d <= 1'b0;
            s_ready  <= 1'b0;
            s_term   <= 1'b0;
            s_abort  <= 1'b0;
            lb_wr    <= 1'b0;
            lb_rd    <= 1'b0;
            lb_addr  <= '0;
            lb_wdata <= '0;
            lb_be    <= '0;
            adio_in  <= '0;
        end else begin
            st       <= nxt;
            cnt      <= (st == nxt && wait_st) ? cnt + 8'd1 : 8'd0;
            s_data_d <= s_data;
            s_ready  <= nxt == WR_WAIT || nxt == RD_DONE;
            s_term   <= nxt != IDLE;
            s_abort  <= hit_tmo;
            lb_wr    <= nxt == WR_ISSUE && be_nxt != 4'd0 && !hit_tmo;
            lb_rd    <= nxt == RD_ISSUE;
            lb_be    <= be_nxt;
            if (claim)
                lb_addr <= addr[ADDR_W-1:2];
            if (st == WR_WAIT && s_data_vld)
                lb_wdata <= adio_out;
            if (st == RD_WAIT && lb_ack && !expired)
                adio_in <= lb_rdata;
        end
    end
endmodule
